// File: rtl/ahb3lite_apb_bridge_if.sv
// AHB3-Lite slave side and APB4 master side of the bridge, bundled as one interface.
// The bridge connects through the slave modport; the environment uses master.
interface ahb3lite_apb_bridge_if #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int PADDR_SIZE = 8,
  parameter int PDATA_SIZE = 32
);
  logic                    HSEL;
  logic [HADDR_SIZE-1:0]   HADDR;
  logic [HDATA_SIZE-1:0]   HWDATA;
  logic [HDATA_SIZE-1:0]   HRDATA;
  logic                    HWRITE;
  logic [2:0]              HSIZE;
  logic [2:0]              HBURST;
  logic [3:0]              HPROT;
  logic [1:0]              HTRANS;
  logic                    HMASTLOCK;
  logic                    HREADY;
  logic                    HREADYOUT;
  logic                    HRESP;

  logic                    PSEL;
  logic                    PENABLE;
  logic [2:0]              PPROT;
  logic                    PWRITE;
  logic [PDATA_SIZE/8-1:0] PSTRB;
  logic [PADDR_SIZE-1:0]   PADDR;
  logic [PDATA_SIZE-1:0]   PWDATA;
  logic [PDATA_SIZE-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
           HMASTLOCK, HREADY,
    output HRDATA, HREADYOUT, HRESP,
    output PSEL, PENABLE, PPROT, PWRITE, PSTRB, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
           HMASTLOCK, HREADY,
    input  HRDATA, HREADYOUT, HRESP,
    input  PSEL, PENABLE, PPROT, PWRITE, PSTRB, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/ahb3lite_apb_bridge.sv
// AHB3-Lite slave to APB4 master bridge: every accepted AHB beat becomes one
// APB SETUP/ACCESS pair; misaligned or oversized beats get a two-cycle ERROR.
module ahb3lite_apb_bridge #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int PADDR_SIZE = 8,
  parameter int PDATA_SIZE = 32
) (
  input logic                  HCLK,
  input logic                  HRESETn,
  ahb3lite_apb_bridge_if.slave bus
);

  localparam int STRB_W   = PDATA_SIZE / 8;
  localparam int LSB_W    = $clog2(STRB_W);
  localparam int MAX_SIZE = $clog2(HDATA_SIZE / 8);

  if (PDATA_SIZE != HDATA_SIZE) begin : g_width_check
    $error("ahb3lite_apb_bridge: PDATA_SIZE must equal HDATA_SIZE");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               accept;
  logic               legal;
  logic               apb_done;
  logic [LSB_W-1:0]   align_mask;
  logic [STRB_W-1:0]  strb_nxt;
  int                 byte_lo;
  int                 byte_cnt;
  logic               unused_inputs;

  assign accept   = bus.HSEL && bus.HREADY && bus.HTRANS[1];
  assign apb_done = bus.PSEL && bus.PENABLE && bus.PREADY;
  assign bus.PWDATA = bus.HWDATA;

  assign unused_inputs = ^{bus.HBURST, bus.HMASTLOCK, bus.HPROT[3:2],
                           bus.HADDR[HADDR_SIZE-1:PADDR_SIZE]};

  // Size/alignment legality and byte lanes of the beat in its address phase.
  always_comb begin
    byte_lo    = int'(bus.HADDR[LSB_W-1:0]);
    byte_cnt   = 1 << bus.HSIZE;
    align_mask = '0;
    strb_nxt   = '0;
    for (int i = 0; i < LSB_W; i++) begin
      align_mask[i] = (i < int'(bus.HSIZE));
    end
    legal = (int'(bus.HSIZE) <= MAX_SIZE) &&
            ((bus.HADDR[LSB_W-1:0] & align_mask) == '0);
    for (int i = 0; i < STRB_W; i++) begin
      strb_nxt[i] = bus.HWRITE && (i >= byte_lo) && (i < byte_lo + byte_cnt);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_ERR2: begin
        if (accept) begin
          state_nxt = legal ? ST_SETUP : ST_ERR1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (apb_done) begin
          state_nxt = bus.PSLVERR ? ST_ERR1 : ST_IDLE;
        end
      end
      ST_ERR1: begin
        state_nxt = ST_ERR2;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs are decoded from the next state so they leave a flop.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      bus.PSEL      <= 1'b0;
      bus.PENABLE   <= 1'b0;
      bus.HREADYOUT <= 1'b1;
      bus.HRESP     <= 1'b0;
    end else begin
      bus.PSEL      <= (state_nxt == ST_SETUP) || (state_nxt == ST_ACCESS);
      bus.PENABLE   <= (state_nxt == ST_ACCESS);
      bus.HREADYOUT <= (state_nxt == ST_IDLE) || (state_nxt == ST_ERR2);
      bus.HRESP     <= (state_nxt == ST_ERR1) || (state_nxt == ST_ERR2);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      bus.PADDR  <= '0;
      bus.PWRITE <= 1'b0;
      bus.PSTRB  <= '0;
      bus.PPROT  <= '0;
    end else if (accept && ((state == ST_IDLE) || (state == ST_ERR2))) begin
      bus.PADDR  <= bus.HADDR[PADDR_SIZE-1:0];
      bus.PWRITE <= bus.HWRITE;
      bus.PSTRB  <= strb_nxt;
      bus.PPROT  <= {~bus.HPROT[0], 1'b0, bus.HPROT[1]};
    end
  end

  // Read data only moves on a successful read completion.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      bus.HRDATA <= '0;
    end else if ((state == ST_ACCESS) && apb_done && !bus.PSLVERR && !bus.PWRITE) begin
      bus.HRDATA <= bus.PRDATA;
    end
  end

endmodule

// File: tb/tb_ahb3lite_apb_bridge.sv
// Randomized scoreboard bench for the AHB3-Lite to APB4 bridge.
// Stimulus pushes expected AHB responses and APB accesses; monitors pop and compare.
module tb_ahb3lite_apb_bridge;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  typedef struct {
    int          waits;
    bit          resp;
    logic [31:0] rdata;
  } ahb_exp_t;

  typedef struct {
    logic [7:0]  addr;
    bit          write;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [31:0] wdata;
  } apb_exp_t;

  typedef struct {
    int          waits;
    bit          err;
    logic [31:0] rdata;
  } apb_cfg_t;

  logic HCLK = 1'b0;
  logic HRESETn;

  ahb3lite_apb_bridge_if bif ();

  ahb3lite_apb_bridge dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bif.slave)
  );

  assign bif.HREADY = bif.HREADYOUT;

  always #5 HCLK = ~HCLK;

  ahb_exp_t    ahb_q[$];
  apb_exp_t    apb_q[$];
  apb_cfg_t    cfg_q[$];
  logic [31:0] model_rdata;
  int          check_count = 0;
  int          error_count = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one address phase, record what the bridge must do with it, then
  // hold it until accepted and present its write data in the data phase.
  task automatic applyStimulus(input logic [1:0] trans, input bit sel, input bit write,
                               input logic [31:0] addr, input logic [2:0] size,
                               input logic [3:0] prot, input logic [31:0] wdata,
                               input int waits, input bit err, input logic [31:0] rdata);
    ahb_exp_t e;
    apb_exp_t a;
    apb_cfg_t c;
    int       nbytes;
    bit       legal;
    bit       rdy;
    int       guard;
    bif.HSEL      = sel;
    bif.HTRANS    = trans;
    bif.HADDR     = addr;
    bif.HWRITE    = write;
    bif.HSIZE     = size;
    bif.HPROT     = prot;
    bif.HBURST    = 3'($urandom);
    bif.HMASTLOCK = 1'($urandom);
    nbytes = 1 << size;
    legal  = (size <= 3'd2) && ((addr % nbytes) == 0);
    if (sel) begin
      if (!trans[1]) begin
        e.waits = 0;
        e.resp  = 1'b0;
      end else if (!legal) begin
        e.waits = 1;
        e.resp  = 1'b1;
      end else begin
        a.addr  = addr[7:0];
        a.write = write;
        a.strb  = write ? 4'(((1 << nbytes) - 1) << addr[1:0]) : 4'b0000;
        a.prot  = {~prot[0], 1'b0, prot[1]};
        a.wdata = wdata;
        apb_q.push_back(a);
        c.waits = waits;
        c.err   = err;
        c.rdata = rdata;
        cfg_q.push_back(c);
        e.waits = 2 + waits + (err ? 1 : 0);
        e.resp  = err;
        if (!write && !err) model_rdata = rdata;
      end
      e.rdata = model_rdata;
      ahb_q.push_back(e);
    end
    guard = 0;
    do begin
      @(negedge HCLK);
      #1;
      rdy = bif.HREADY;
      @(posedge HCLK);
      #1;
      guard++;
    end while (!rdy && guard < 64);
    if (!rdy) checkOutput("accept_timeout", 64'(rdy), 64'(1));
    bif.HWDATA = wdata;
  endtask

  task automatic idleBus(input int cycles);
    bit rdy;
    int guard;
    bif.HSEL   = 1'b0;
    bif.HTRANS = HT_IDLE;
    guard = 0;
    do begin
      @(negedge HCLK);
      #1;
      rdy = bif.HREADY;
      guard++;
    end while (!rdy && guard < 64);
    if (!rdy) checkOutput("idle_timeout", 64'(rdy), 64'(1));
    repeat (cycles) @(posedge HCLK);
    #1;
  endtask

  // APB slave model: serves each access with its queued wait count and status,
  // and drives junk on PREADY/PSLVERR/PRDATA whenever they must be ignored.
  always begin : apbResponder
    apb_cfg_t c;
    bit       r_active;
    int       r_cnt;
    bit       r_err;
    logic [31:0] r_data;
    @(negedge HCLK);
    if (!HRESETn) begin
      r_active    = 1'b0;
      bif.PREADY  = 1'b0;
      bif.PSLVERR = 1'b0;
      bif.PRDATA  = '0;
    end else if (bif.PSEL && bif.PENABLE) begin
      if (!r_active) begin
        r_active = 1'b1;
        if (cfg_q.size() > 0) begin
          c      = cfg_q.pop_front();
          r_cnt  = c.waits;
          r_err  = c.err;
          r_data = c.rdata;
        end else begin
          r_cnt  = 0;
          r_err  = 1'b0;
          r_data = '0;
        end
      end
      if (r_cnt > 0) begin
        bif.PREADY  = 1'b0;
        bif.PSLVERR = 1'($urandom);
        bif.PRDATA  = $urandom;
        r_cnt--;
      end else begin
        bif.PREADY  = 1'b1;
        bif.PSLVERR = r_err;
        bif.PRDATA  = r_data;
        r_active    = 1'b0;
      end
    end else begin
      r_active    = 1'b0;
      bif.PREADY  = 1'($urandom);
      bif.PSLVERR = 1'($urandom);
      bif.PRDATA  = $urandom;
    end
  end

  always begin : ahbMonitor
    ahb_exp_t e;
    bit dp_active;
    int dp_waits;
    int dp_err_cycles;
    @(negedge HCLK);
    #1;
    if (!HRESETn) begin
      dp_active = 1'b0;
    end else begin
      if (dp_active) begin
        if (!bif.HREADYOUT) begin
          dp_waits++;
          if (bif.HRESP) dp_err_cycles++;
          if (dp_waits > 64) begin
            checkOutput("ahb_data_phase_timeout", 64'(dp_waits), 64'(64));
            dp_active = 1'b0;
          end
        end else begin
          if (ahb_q.size() == 0) begin
            checkOutput("ahb_unexpected_response", 64'(ahb_q.size()), 64'(1));
          end else begin
            e = ahb_q.pop_front();
            checkOutput("ahb_wait_states", 64'(dp_waits), 64'(e.waits));
            checkOutput("ahb_hresp", 64'(bif.HRESP), 64'(e.resp));
            checkOutput("ahb_err_first_cycle", 64'(dp_err_cycles), 64'(e.resp ? 1 : 0));
            checkOutput("ahb_hrdata", 64'(bif.HRDATA), 64'(e.rdata));
          end
          dp_active = 1'b0;
        end
      end
      if (!dp_active && bif.HSEL && bif.HREADY) begin
        dp_active     = 1'b1;
        dp_waits      = 0;
        dp_err_cycles = 0;
      end
    end
  end

  always begin : apbMonitor
    apb_exp_t a;
    bit       in_setup;
    logic [7:0] cap_addr;
    logic [3:0] cap_strb;
    logic [2:0] cap_prot;
    logic       cap_write;
    @(negedge HCLK);
    #1;
    if (!HRESETn) begin
      in_setup = 1'b0;
    end else if (bif.PSEL && !bif.PENABLE) begin
      in_setup  = 1'b1;
      cap_addr  = bif.PADDR;
      cap_strb  = bif.PSTRB;
      cap_prot  = bif.PPROT;
      cap_write = bif.PWRITE;
    end else if (bif.PSEL && bif.PENABLE && bif.PREADY) begin
      checkOutput("apb_setup_before_access", 64'(in_setup), 64'(1));
      checkOutput("apb_paddr_stable", 64'(bif.PADDR), 64'(cap_addr));
      checkOutput("apb_pstrb_stable", 64'(bif.PSTRB), 64'(cap_strb));
      checkOutput("apb_pprot_stable", 64'(bif.PPROT), 64'(cap_prot));
      checkOutput("apb_pwrite_stable", 64'(bif.PWRITE), 64'(cap_write));
      if (apb_q.size() == 0) begin
        checkOutput("apb_unexpected_access", 64'(apb_q.size()), 64'(1));
      end else begin
        a = apb_q.pop_front();
        checkOutput("apb_paddr", 64'(bif.PADDR), 64'(a.addr));
        checkOutput("apb_pwrite", 64'(bif.PWRITE), 64'(a.write));
        checkOutput("apb_pstrb", 64'(bif.PSTRB), 64'(a.strb));
        checkOutput("apb_pprot", 64'(bif.PPROT), 64'(a.prot));
        if (a.write) checkOutput("apb_pwdata", 64'(bif.PWDATA), 64'(a.wdata));
      end
      in_setup = 1'b0;
    end else if (bif.PENABLE && !bif.PSEL) begin
      checkOutput("apb_penable_without_psel", 64'(bif.PSEL), 64'(1));
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_psel"}, 64'(bif.PSEL), 64'(0));
    checkOutput({tag, "_penable"}, 64'(bif.PENABLE), 64'(0));
    checkOutput({tag, "_hreadyout"}, 64'(bif.HREADYOUT), 64'(1));
    checkOutput({tag, "_hresp"}, 64'(bif.HRESP), 64'(0));
    checkOutput({tag, "_hrdata"}, 64'(bif.HRDATA), 64'(0));
    checkOutput({tag, "_pwrite"}, 64'(bif.PWRITE), 64'(0));
    checkOutput({tag, "_paddr"}, 64'(bif.PADDR), 64'(0));
    checkOutput({tag, "_pstrb"}, 64'(bif.PSTRB), 64'(0));
    checkOutput({tag, "_pprot"}, 64'(bif.PPROT), 64'(0));
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int guard;
    HRESETn       = 1'b0;
    model_rdata   = '0;
    bif.HSEL      = 1'b0;
    bif.HTRANS    = HT_IDLE;
    bif.HADDR     = '0;
    bif.HWRITE    = 1'b0;
    bif.HSIZE     = 3'd0;
    bif.HPROT     = 4'd0;
    bif.HBURST    = 3'd0;
    bif.HMASTLOCK = 1'b0;
    bif.HWDATA    = '0;

    @(negedge HCLK);
    #1;
    checkResetOutputs("reset");
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;

    $display("[TB] directed: word write, slow read, narrow writes");
    applyStimulus(HT_NONSEQ, 1'b1, 1'b1, 32'h14, 3'd2, 4'b0011, 32'hDEADBEEF, 0, 1'b0, 32'h0);
    applyStimulus(HT_NONSEQ, 1'b1, 1'b0, 32'h08, 3'd2, 4'b0010, 32'h0, 3, 1'b0, 32'h12345678);
    applyStimulus(HT_NONSEQ, 1'b1, 1'b1, 32'h03, 3'd0, 4'b0001, 32'hAABBCCDD, 0, 1'b0, 32'h0);
    applyStimulus(HT_NONSEQ, 1'b1, 1'b1, 32'h02, 3'd1, 4'b0000, 32'h11223344, 1, 1'b0, 32'h0);

    $display("[TB] directed: slave error, illegal size and alignment");
    applyStimulus(HT_NONSEQ, 1'b1, 1'b1, 32'h20, 3'd2, 4'b0011, 32'h55AA55AA, 1, 1'b1, 32'h0);
    applyStimulus(HT_IDLE,   1'b1, 1'b0, 32'h24, 3'd2, 4'b0000, 32'h0, 0, 1'b0, 32'h0);
    applyStimulus(HT_NONSEQ, 1'b1, 1'b1, 32'h01, 3'd1, 4'b0000, 32'hCAFEF00D, 0, 1'b0, 32'h0);
    applyStimulus(HT_NONSEQ, 1'b1, 1'b0, 32'h00, 3'd3, 4'b0000, 32'h0, 0, 1'b0, 32'h0);
    applyStimulus(HT_NONSEQ, 1'b1, 1'b0, 32'h30, 3'd2, 4'b0000, 32'h0, 0, 1'b1, 32'h0BADF00D);

    $display("[TB] directed: back-to-back, IDLE and BUSY");
    applyStimulus(HT_NONSEQ, 1'b1, 1'b1, 32'h40, 3'd2, 4'b0001, 32'h01020304, 0, 1'b0, 32'h0);
    applyStimulus(HT_NONSEQ, 1'b1, 1'b0, 32'h44, 3'd2, 4'b0001, 32'h0, 0, 1'b0, 32'h87654321);
    applyStimulus(HT_BUSY,   1'b1, 1'b0, 32'h48, 3'd2, 4'b0000, 32'h0, 0, 1'b0, 32'h0);
    applyStimulus(HT_IDLE,   1'b1, 1'b0, 32'h4C, 3'd2, 4'b0000, 32'h0, 0, 1'b0, 32'h0);
    applyStimulus(HT_SEQ,    1'b1, 1'b0, 32'h4C, 3'd2, 4'b0000, 32'h0, 2, 1'b0, 32'hFEEDFACE);
    idleBus(2);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 60; i++) begin
      logic [1:0]  tr;
      logic [2:0]  sz;
      logic [31:0] ad;
      int          pick;
      pick = int'($urandom_range(0, 9));
      tr = (pick < 6) ? HT_NONSEQ : (pick < 8) ? HT_SEQ : (pick == 8) ? HT_BUSY : HT_IDLE;
      sz = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      ad = $urandom;
      if ($urandom_range(0, 4) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
      applyStimulus(tr, $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), ad, sz,
                    4'($urandom), $urandom, int'($urandom_range(0, 3)),
                    $urandom_range(0, 7) == 0, $urandom);
    end
    idleBus(3);

    $display("[TB] reset asserted in the middle of an APB access");
    applyStimulus(HT_NONSEQ, 1'b1, 1'b0, 32'h50, 3'd2, 4'b0000, 32'h0, 20, 1'b0, 32'hA5A5A5A5);
    bif.HSEL   = 1'b0;
    bif.HTRANS = HT_IDLE;
    guard = 0;
    do begin
      @(negedge HCLK);
      #1;
      guard++;
    end while (!(bif.PSEL && bif.PENABLE) && guard < 20);
    checkOutput("reach_access_before_reset", 64'(bif.PSEL && bif.PENABLE), 64'(1));
    #2;
    HRESETn = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    ahb_q.delete();
    apb_q.delete();
    cfg_q.delete();
    model_rdata = '0;
    @(posedge HCLK);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;

    applyStimulus(HT_NONSEQ, 1'b1, 1'b0, 32'h60, 3'd2, 4'b0000, 32'h0, 1, 1'b0, 32'h13579BDF);
    applyStimulus(HT_NONSEQ, 1'b1, 1'b1, 32'h66, 3'd1, 4'b0010, 32'h2468ACE0, 0, 1'b0, 32'h0);
    idleBus(3);

    checkOutput("scoreboard_ahb_drained", 64'(ahb_q.size()), 64'(0));
    checkOutput("scoreboard_apb_drained", 64'(apb_q.size()), 64'(0));
    checkOutput("scoreboard_cfg_drained", 64'(cfg_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
